// File: rtl/lut_neuron_loader.sv
// Reloadable LogicNets neuron truth table: streamed config load, then 1-cycle registered lookups.
// Config port stalls (cfg_ready=0) outside LOAD; the lookup path has no backpressure and drops requests unless READY.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                loaded,
  output logic [15:0]         table_sum,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY
  } state_t;

  state_t              r_state;
  logic [IN_BITS-1:0]  r_addr;
  logic [OUT_BITS-1:0] r_table [DEPTH];

  logic        w_accept;
  logic        w_last;
  logic        w_lookup;
  logic [15:0] w_beat_ext;

  // A restart pulse wins over a beat offered in the same cycle.
  assign w_accept   = (r_state == ST_LOAD) && cfg_valid && !load_start;
  assign w_last     = (r_addr == {IN_BITS{1'b1}});
  assign w_lookup   = (r_state == ST_READY) && in_valid;
  assign w_beat_ext = 16'(cfg_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_addr    <= '0;
      cfg_ready <= 1'b0;
      loaded    <= 1'b0;
      table_sum <= 16'h0000;
    end else begin
      case (r_state)
        ST_EMPTY, ST_READY: begin
          if (load_start) begin
            r_state   <= ST_LOAD;
            r_addr    <= '0;
            table_sum <= 16'h0000;
            loaded    <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            r_addr    <= '0;
            table_sum <= 16'h0000;
          end else if (w_accept) begin
            table_sum <= table_sum + w_beat_ext;
            r_addr    <= r_addr + 1'b1;
            if (w_last) begin
              r_state   <= ST_READY;
              cfg_ready <= 1'b0;
              loaded    <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          cfg_ready <= 1'b0;
          loaded    <= 1'b0;
        end
      endcase
    end
  end

  // Table storage has no reset so it maps onto distributed RAM; loaded gates visibility instead.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_table[r_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      M1        <= '0;
    end else begin
      out_valid <= w_lookup;
      if (w_lookup) begin
        M1 <= r_table[M0];
      end
    end
  end

endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Runtime-programmable LogicNets neuron: the write side of a neuron truth table. Accepts a stream of output codes over a valid/ready configuration port, stores them in a distributed-RAM table of 2^IN_BITS entries, then serves registered lookups. It replaces a fixed per-neuron ROM wherever a layer's tables must be reloaded after synthesis. It sits between the configuration DMA/CSR path and the layer datapath.

## Interface

- IN_BITS, 8, lookup address width (fan-in × input bits); table depth 2^IN_BITS
- OUT_BITS, 2, width of each stored output code
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  pulse: begin (re)loading table from address 0
- cfg_valid  input  1  cfg_data valid
- cfg_data  input  OUT_BITS  table entry for current load address
- cfg_ready  output  1  entry accepted when cfg_valid && cfg_ready
- loaded  output  1  table fully written, lookups enabled
- table_sum  output  16  modulo-2^16 sum of entries written in current/last load
- in_valid  input  1  lookup request
- M0  input  IN_BITS  lookup address (binary value = table index)
- out_valid  output  1  M1 valid
- M1  output  OUT_BITS  registered table output

## Operation

- States: EMPTY (after reset, no valid table), LOAD, READY.
- EMPTY/READY + load_start -> LOAD: addr counter := 0, table_sum := 0, loaded := 0.
- LOAD: cfg_ready = 1. Each accepted beat writes cfg_data to table[addr], adds zero-extended cfg_data to table_sum, increments addr.
- Beat accepted at addr = 2^IN_BITS−1 -> READY, loaded := 1. No further beats accepted (cfg_ready = 0).
- load_start during LOAD: restart at addr 0, table_sum := 0; a beat offered in the same cycle is not accepted.
- cfg_valid outside LOAD: ignored, cfg_ready = 0, no write.
- READY: in_valid samples M0; next cycle out_valid = 1, M1 = table[M0]. in_valid low -> out_valid = 0, M1 holds last value.
- in_valid while in EMPTY or LOAD: dropped, out_valid stays 0.
- load_start and in_valid in the same READY cycle: lookup accepted against the old table; state goes to LOAD.
- Table contents are not cleared by rst; loaded = 0 makes stale content unreachable.
- Entry ordering: ascending binary address, entry k at M0 = k.

## Timing

- Reset values: state EMPTY, cfg_ready 0, loaded 0, out_valid 0, M1 0, table_sum 0, addr 0.
- cfg_ready is a registered/state-decoded output, high from the cycle after load_start.
- Full load: exactly 2^IN_BITS accepted beats; with cfg_valid held high, loaded rises 2^IN_BITS cycles after cfg_ready first goes high (+1 registration cycle).
- Lookup latency: 1 cycle, fully pipelined, one result per cycle; no backpressure on the lookup path.
- Write at addr A and read of A can never coincide (reads disabled in LOAD); no read-during-write behaviour is defined.
- table_sum updates the cycle after each accepted beat; stable in READY.
- rst mid-load: EMPTY next cycle; partial table discarded logically, loaded 0.

## Test plan

- Reset: assert rst 2 cycles -> cfg_ready 0, loaded 0, out_valid 0, M1 2'b00, table_sum 16'h0000; in_valid with M0 8'h05 -> out_valid stays 0.
- Full load, IN_BITS=8, OUT_BITS=2, entry[k] = k[1:0], cfg_valid held high -> exactly 256 beats accepted, loaded = 1, cfg_ready = 0, table_sum = 16'h0180.
- Lookups after load: M0 8'h0E, 8'hFF, 8'h00 on consecutive cycles -> M1 2'b10, 2'b11, 2'b00 one cycle later each, out_valid high 3 cycles.
- Throttled load: cfg_valid toggling pseudo-randomly, entry[k] = ~k[1:0] -> same 256 writes, table_sum 16'h0180, lookup 8'h01 -> 2'b10.
- Restart mid-load: load_start after 100 beats, then 256 beats of 2'b01 -> loaded only after the second 256, table_sum 16'h0100, every lookup returns 2'b01.
- Reload while READY: load_start with in_valid M0 8'h03 in same cycle -> out_valid 1 with old entry (2'b11 from scenario 2); loaded 0 next cycle; later in_valid dropped until reload completes.
